// File: rtl/gray_pkg.sv
// Shared definitions for the RGB-to-gray pipeline: weighting modes, per-mode
// coefficients and the fixed-point rounding constants.
package gray_pkg;

    localparam int MODE_W = 2;
    localparam int COEF_W = 8;
    localparam int ROUND  = 128;
    localparam int SHIFT  = 8;

    typedef enum logic [MODE_W-1:0] {
        MODE_601 = 2'd0,
        MODE_709 = 2'd1,
        MODE_AVG = 2'd2,
        MODE_MAX = 2'd3
    } gray_mode_e;

    typedef struct packed {
        logic [COEF_W-1:0] cr;
        logic [COEF_W-1:0] cg;
        logic [COEF_W-1:0] cb;
    } coef_t;

    localparam coef_t COEF_601 = '{cr: 8'd77, cg: 8'd150, cb: 8'd29};
    localparam coef_t COEF_709 = '{cr: 8'd54, cg: 8'd183, cb: 8'd19};
    localparam coef_t COEF_AVG = '{cr: 8'd85, cg: 8'd85,  cb: 8'd86};
    localparam coef_t COEF_NIL = '{cr: 8'd0,  cg: 8'd0,   cb: 8'd0};

    // MODE_MAX never multiplies, so it maps to all-zero weights.
    function automatic coef_t get_coef(input gray_mode_e mode);
        coef_t c;
        case (mode)
            MODE_601: c = COEF_601;
            MODE_709: c = COEF_709;
            MODE_AVG: c = COEF_AVG;
            default:  c = COEF_NIL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/gray_lane.sv
// One pixel lane of the gray pipeline: S2 holds weighted products (or raw
// channels in max mode), S3 holds the rounded, saturated or max-selected gray.
module gray_lane
    import gray_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_s2_load,
    input  logic               i_s3_load,
    input  logic [PIX_W-1:0]   i_r,
    input  logic [PIX_W-1:0]   i_g,
    input  logic [PIX_W-1:0]   i_b,
    input  logic [MODE_W-1:0]  i_mode,
    output logic [PIX_W-1:0]   o_gray
);

    localparam int PROD_W = PIX_W + COEF_W;
    localparam int SUM_W  = PIX_W + 10;

    coef_t              w_coef;
    logic               w_is_max;
    logic [PROD_W-1:0]  w_pr;
    logic [PROD_W-1:0]  w_pg;
    logic [PROD_W-1:0]  w_pb;

    logic [PROD_W-1:0]  r_pr;
    logic [PROD_W-1:0]  r_pg;
    logic [PROD_W-1:0]  r_pb;
    logic [MODE_W-1:0]  r_s2_mode;

    logic [SUM_W-1:0]   w_sum;
    logic [SUM_W-1:0]   w_shifted;
    logic [PIX_W-1:0]   w_sat;
    logic [PIX_W-1:0]   w_max;
    logic [PIX_W-1:0]   w_gray_next;
    logic [PIX_W-1:0]   r_gray;

    assign w_coef   = get_coef(gray_mode_e'(i_mode));
    assign w_is_max = (i_mode == MODE_MAX);

    // Max mode passes the raw channels through the product registers so every
    // mode sees the same S2/S3 latency.
    always_comb begin
        w_pr = {{COEF_W{1'b0}}, i_r};
        w_pg = {{COEF_W{1'b0}}, i_g};
        w_pb = {{COEF_W{1'b0}}, i_b};
        if (!w_is_max) begin
            w_pr = {{COEF_W{1'b0}}, i_r} * {{PIX_W{1'b0}}, w_coef.cr};
            w_pg = {{COEF_W{1'b0}}, i_g} * {{PIX_W{1'b0}}, w_coef.cg};
            w_pb = {{COEF_W{1'b0}}, i_b} * {{PIX_W{1'b0}}, w_coef.cb};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pr      <= '0;
            r_pg      <= '0;
            r_pb      <= '0;
            r_s2_mode <= MODE_601;
        end else if (i_s2_load) begin
            r_pr      <= w_pr;
            r_pg      <= w_pg;
            r_pb      <= w_pb;
            r_s2_mode <= i_mode;
        end
    end

    assign w_sum     = {2'b00, r_pr} + {2'b00, r_pg} + {2'b00, r_pb} + SUM_W'(ROUND);
    assign w_shifted = w_sum >> SHIFT;
    assign w_sat     = (|w_shifted[SUM_W-1:PIX_W]) ? {PIX_W{1'b1}} : w_shifted[PIX_W-1:0];

    always_comb begin
        w_max = r_pr[PIX_W-1:0];
        if (r_pg[PIX_W-1:0] > w_max) begin
            w_max = r_pg[PIX_W-1:0];
        end
        if (r_pb[PIX_W-1:0] > w_max) begin
            w_max = r_pb[PIX_W-1:0];
        end
    end

    assign w_gray_next = (r_s2_mode == MODE_MAX) ? w_max : w_sat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gray <= '0;
        end else if (i_s3_load) begin
            r_gray <= w_gray_next;
        end
    end

    assign o_gray = r_gray;

endmodule

// File: rtl/rgb_to_gray_pipe.sv
// Three-stage RGB-to-gray converter, LANES pixels per beat, with valid/ready
// backpressure and a wrapping count of delivered output beats.
module rgb_to_gray_pipe
    import gray_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int LANES = 1,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*PIX_W-1:0]   in_r,
    input  logic [LANES*PIX_W-1:0]   in_g,
    input  logic [LANES*PIX_W-1:0]   in_b,
    input  logic [1:0]               mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*PIX_W-1:0]   out_gray,
    output logic [CNT_W-1:0]         out_count,
    input  logic                     count_clr
);

    logic                    r_s1_valid;
    logic                    r_s2_valid;
    logic                    r_s3_valid;
    logic [LANES*PIX_W-1:0]  r_s1_r;
    logic [LANES*PIX_W-1:0]  r_s1_g;
    logic [LANES*PIX_W-1:0]  r_s1_b;
    logic [MODE_W-1:0]       r_s1_mode;
    logic [CNT_W-1:0]        r_count;

    logic                    w_s1_load;
    logic                    w_s2_load;
    logic                    w_s3_load;
    logic                    w_in_fire;
    logic                    w_out_fire;

    // A stage may load when empty or when its successor takes its contents.
    assign w_s3_load  = !r_s3_valid || out_ready;
    assign w_s2_load  = !r_s2_valid || w_s3_load;
    assign w_s1_load  = !r_s1_valid || w_s2_load;
    assign w_in_fire  = in_valid && w_s1_load;
    assign w_out_fire = r_s3_valid && out_ready;

    assign in_ready  = w_s1_load;
    assign out_valid = r_s3_valid;
    assign out_count = r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
        end else begin
            if (w_s1_load) begin
                r_s1_valid <= in_valid;
            end
            if (w_s2_load) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s3_load) begin
                r_s3_valid <= r_s2_valid;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_r    <= '0;
            r_s1_g    <= '0;
            r_s1_b    <= '0;
            r_s1_mode <= MODE_601;
        end else if (w_in_fire) begin
            r_s1_r    <= in_r;
            r_s1_g    <= in_g;
            r_s1_b    <= in_b;
            r_s1_mode <= mode;
        end
    end

    // Clear has priority over a same-cycle transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (count_clr) begin
            r_count <= '0;
        end else if (w_out_fire) begin
            r_count <= r_count + 1'b1;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        gray_lane #(
            .PIX_W (PIX_W)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .i_s2_load (w_s2_load && r_s1_valid),
            .i_s3_load (w_s3_load && r_s2_valid),
            .i_r       (r_s1_r[l*PIX_W +: PIX_W]),
            .i_g       (r_s1_g[l*PIX_W +: PIX_W]),
            .i_b       (r_s1_b[l*PIX_W +: PIX_W]),
            .i_mode    (r_s1_mode),
            .o_gray    (out_gray[l*PIX_W +: PIX_W])
        );
    end

endmodule

// File: tb/tb_rgb_to_gray_pipe.sv
// Directed bench: a single-lane, 16-bit-counter instance and a two-lane,
// 4-bit-counter instance checked against hand-computed gray values.
module tb_rgb_to_gray_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_r = '0;
    logic [7:0]  in_g = '0;
    logic [7:0]  in_b = '0;
    logic [1:0]  mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_gray;
    logic [15:0] out_count;
    logic        count_clr = 1'b0;

    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [15:0] b_in_r = '0;
    logic [15:0] b_in_g = '0;
    logic [15:0] b_in_b = '0;
    logic [1:0]  b_mode = '0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b0;
    logic [15:0] b_out_gray;
    logic [3:0]  b_out_count;
    logic        b_count_clr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rgb_to_gray_pipe #(.PIX_W(8), .LANES(1), .CNT_W(16)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r      (in_r),
        .in_g      (in_g),
        .in_b      (in_b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_gray  (out_gray),
        .out_count (out_count),
        .count_clr (count_clr)
    );

    rgb_to_gray_pipe #(.PIX_W(8), .LANES(2), .CNT_W(4)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_r      (b_in_r),
        .in_g      (b_in_g),
        .in_b      (b_in_b),
        .mode      (b_mode),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_gray  (b_out_gray),
        .out_count (b_out_count),
        .count_clr (b_count_clr)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [7:0] r, input logic [7:0] g,
                            input logic [7:0] b, input logic [1:0] m);
        in_valid = 1'b1;
        in_r     = r;
        in_g     = g;
        in_b     = b;
        mode     = m;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) cyc();
        n_checks++;
        if (out_valid !== 1'b0 || out_gray !== 8'd0 || out_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: out_valid=%b out_gray=%0d out_count=%0d, required 0/0/0",
                     out_valid, out_gray, out_count);
        end
        rst = 1'b1;
        cyc();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b b_in_ready=%b b_out_valid=%b, required 1/0/1/0",
                     in_ready, out_valid, b_in_ready, b_out_valid);
        end
    endtask

    task automatic test_single_white();
        out_ready = 1'b1;
        set_beat(8'd255, 8'd255, 8'd255, 2'd0);
        cyc();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL white_lat1: out_valid=%b, required 0", out_valid);
        end
        cyc();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL white_lat2: out_valid=%b, required 0", out_valid);
        end
        cyc();
        n_checks++;
        if (out_valid !== 1'b1 || out_gray !== 8'd255) begin
            n_fail++;
            $display("FAIL white_result: out_valid=%b out_gray=%0d, required 1/255", out_valid, out_gray);
        end
        cyc();
        n_checks++;
        if (out_count !== 16'd1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL white_count: out_count=%0d out_valid=%b, required 1/0", out_count, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vr [4];
        logic [7:0] vg [4];
        logic [7:0] vb [4];
        logic [1:0] vm [4];
        logic [7:0] ex [4];
        vr = '{8'd100, 8'd0,   8'd90, 8'd10};
        vg = '{8'd150, 8'd255, 8'd30, 8'd200};
        vb = '{8'd50,  8'd0,   8'd60, 8'd30};
        vm = '{2'd0,   2'd1,   2'd2,  2'd3};
        ex = '{8'd124, 8'd182, 8'd60, 8'd200};
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            if (k < 4) set_beat(vr[k], vg[k], vb[k], vm[k]);
            else in_valid = 1'b0;
            cyc();
            if (k >= 2 && k <= 5) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_gray !== ex[k-2]) begin
                    n_fail++;
                    $display("FAIL b2b_beat%0d: out_valid=%b out_gray=%0d, required 1/%0d",
                             k - 2, out_valid, out_gray, ex[k-2]);
                end
            end
        end
        n_checks++;
        if (out_valid !== 1'b0 || out_count !== 16'd5) begin
            n_fail++;
            $display("FAIL b2b_drain: out_valid=%b out_count=%0d, required 0/5", out_valid, out_count);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] vr [6];
        logic [7:0] vg [6];
        logic [7:0] vb [6];
        logic [1:0] vm [6];
        logic [7:0] ex [6];
        int n_in;
        int n_rx;
        int stall;
        bit saw_block;
        vr = '{8'd255, 8'd0, 8'd100, 8'd0,   8'd90, 8'd10};
        vg = '{8'd255, 8'd0, 8'd150, 8'd255, 8'd30, 8'd200};
        vb = '{8'd255, 8'd0, 8'd50,  8'd0,   8'd60, 8'd30};
        vm = '{2'd0,   2'd0, 2'd0,   2'd1,   2'd2,  2'd3};
        ex = '{8'd255, 8'd0, 8'd124, 8'd182, 8'd60, 8'd200};
        n_in = 0;
        n_rx = 0;
        stall = -1;
        saw_block = 1'b0;
        count_clr = 1'b1;
        cyc();
        count_clr = 1'b0;
        n_checks++;
        if (out_count !== 16'd0) begin
            n_fail++;
            $display("FAIL bp_clear: out_count=%0d, required 0", out_count);
        end
        for (int c = 0; c < 40 && n_rx < 6; c++) begin
            if (n_in < 6) set_beat(vr[n_in], vg[n_in], vb[n_in], vm[n_in]);
            else in_valid = 1'b0;
            if (stall < 0 && out_valid === 1'b1) stall = 4;
            out_ready = !(stall > 0);
            #1;
            if (in_ready === 1'b0) saw_block = 1'b1;
            if (out_valid === 1'b1) begin
                n_checks++;
                if (out_gray !== ex[n_rx]) begin
                    n_fail++;
                    $display("FAIL bp_beat%0d: out_gray=%0d, required %0d", n_rx, out_gray, ex[n_rx]);
                end
                if (out_ready) n_rx++;
            end
            if (in_valid && in_ready === 1'b1) n_in++;
            if (stall > 0) stall--;
            cyc();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (n_rx != 6 || n_in != 6 || !saw_block) begin
            n_fail++;
            $display("FAIL bp_flow: received=%0d sent=%0d in_ready_dropped=%0d, required 6/6/1",
                     n_rx, n_in, saw_block);
        end
        repeat (3) cyc();
        n_checks++;
        if (out_valid !== 1'b0 || out_count !== 16'd6) begin
            n_fail++;
            $display("FAIL bp_no_dup: out_valid=%b out_count=%0d, required 0/6", out_valid, out_count);
        end
    endtask

    task automatic test_lanes();
        b_out_ready = 1'b1;
        b_in_r = {8'd0, 8'd255};
        b_in_g = 16'd0;
        b_in_b = {8'd255, 8'd0};
        b_mode = 2'd0;
        b_in_valid = 1'b1;
        cyc();
        b_in_valid = 1'b0;
        cyc();
        cyc();
        n_checks++;
        if (b_out_valid !== 1'b1 || b_out_gray !== 16'h1D4D) begin
            n_fail++;
            $display("FAIL lanes_result: out_valid=%b out_gray=%h, required 1/1d4d", b_out_valid, b_out_gray);
        end
        cyc();
        n_checks++;
        if (b_out_count !== 4'd1) begin
            n_fail++;
            $display("FAIL lanes_count: out_count=%0d, required 1", b_out_count);
        end
    endtask

    task automatic test_counter_wrap();
        b_count_clr = 1'b1;
        cyc();
        b_count_clr = 1'b0;
        n_checks++;
        if (b_out_count !== 4'd0) begin
            n_fail++;
            $display("FAIL wrap_clear: out_count=%0d, required 0", b_out_count);
        end
        b_in_valid = 1'b1;
        repeat (17) cyc();
        b_in_valid = 1'b0;
        repeat (4) cyc();
        n_checks++;
        if (b_out_count !== 4'd1) begin
            n_fail++;
            $display("FAIL wrap_17: out_count=%0d, required 1", b_out_count);
        end
        b_in_valid = 1'b1;
        cyc();
        b_in_valid = 1'b0;
        cyc();
        cyc();
        n_checks++;
        if (b_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_setup: out_valid=%b, required 1", b_out_valid);
        end
        b_count_clr = 1'b1;
        cyc();
        b_count_clr = 1'b0;
        n_checks++;
        if (b_out_count !== 4'd0 || b_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_wins: out_count=%0d out_valid=%b, required 0/0", b_out_count, b_out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        bit seen;
        out_ready = 1'b1;
        set_beat(8'd255, 8'd255, 8'd255, 2'd0);
        cyc();
        set_beat(8'd100, 8'd150, 8'd50, 2'd0);
        cyc();
        set_beat(8'd0, 8'd255, 8'd0, 2'd1);
        cyc();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_count !== 16'd6) begin
            n_fail++;
            $display("FAIL mid_setup: out_valid=%b out_count=%0d, required 1/6", out_valid, out_count);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_count !== 16'd0 || out_gray !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_reset: out_valid=%b out_count=%0d out_gray=%0d, required 0/0/0",
                     out_valid, out_count, out_gray);
        end
        cyc();
        cyc();
        rst = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL mid_stale: stale out_valid seen=1, required 0");
        end
        set_beat(8'd90, 8'd30, 8'd60, 2'd2);
        cyc();
        in_valid = 1'b0;
        cyc();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_early: out_valid=%b, required 0", out_valid);
        end
        cyc();
        n_checks++;
        if (out_valid !== 1'b1 || out_gray !== 8'd60) begin
            n_fail++;
            $display("FAIL mid_result: out_valid=%b out_gray=%0d, required 1/60", out_valid, out_gray);
        end
        cyc();
        n_checks++;
        if (out_count !== 16'd1) begin
            n_fail++;
            $display("FAIL mid_count: out_count=%0d, required 1", out_count);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_white();
        test_back_to_back();
        test_backpressure();
        test_lanes();
        test_counter_wrap();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
